amba_axi4_lite_write_slave: RTL and testbench

- AXI4-Lite write-side subordinate endpoint. Consumes the Write Address (AW) and Write Data (W) channels that the AW/W interface checkers monitor.
- Turns each accepted address/data pair into a single-cycle register-file write strobe, then returns a Write Response (B).
- Sits directly downstream of the AW/W link, on the destination side of the link, in front of a simple register bank.
- One transaction in flight at a time.

---
 rtl/amba_axi4_lite_write_slave.sv | 107 ++++++++++
 tb/tb_amba_axi4_lite_write_slave.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/amba_axi4_lite_write_slave.sv
// amba_axi4_lite_write_slave: AXI4-Lite write subordinate turning one AW/W pair into a register write strobe plus a B response.
// Ports: ACLK/ARESETn clock and async active-low reset; AW*/W* address and data channels; B* response channel;
// wr_en/wr_idx/wr_data/wr_strb single-cycle register-bank write port.
module amba_axi4_lite_write_slave #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16,
  parameter int PRIV_ONLY     = 0
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [ADDRESS_WIDTH-1:0]      AWADDR,
  input  logic [2:0]                    AWPROT,
  input  logic                          WVALID,
  output logic                          WREADY,
  input  logic [DATA_WIDTH-1:0]         WDATA,
  input  logic [DATA_WIDTH/8-1:0]       WSTRB,
  output logic                          BVALID,
  input  logic                          BREADY,
  output logic [1:0]                    BRESP,
  output logic                          wr_en,
  output logic [$clog2(NUM_REGS)-1:0]   wr_idx,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [DATA_WIDTH/8-1:0]       wr_strb
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int IW  = $clog2(NUM_REGS);
  localparam int LSB = $clog2(SW);
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
  state_t state;
  logic run, aw_full, w_full, aw_priv, err;
  logic [ADDRESS_WIDTH-1:0] aw_addr, addr_n, idx_n;
  logic [DATA_WIDTH-1:0] w_data, data_n;
  logic [SW-1:0] w_strb, strb_n;
  logic aw_hs, w_hs, priv_n, err_n, go;
  logic unused;
  assign AWREADY = state == IDLE && run && !aw_full;
  assign WREADY  = state == IDLE && run && !w_full;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  // Decode is done on the edge that completes the pair, so the incoming beat is merged with the holds.
  assign addr_n  = aw_hs ? AWADDR : aw_addr;
  assign priv_n  = aw_hs ? AWPROT[0] : aw_priv;
  assign data_n  = w_hs ? WDATA : w_data;
  assign strb_n  = w_hs ? WSTRB : w_strb;
  assign idx_n   = addr_n >> LSB;
  // Full-width compare so high address bits never alias onto a valid register.
  assign err_n   = idx_n >= ADDRESS_WIDTH'(NUM_REGS) || (PRIV_ONLY != 0 && !priv_n);
  assign go      = (aw_full || aw_hs) && (w_full || w_hs);
  assign unused  = ^AWPROT[2:1];
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state   <= IDLE;
      run     <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      aw_priv <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      err     <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= 2'b00;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else begin
      run   <= 1'b1;
      wr_en <= 1'b0;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
        aw_priv <= AWPROT[0];
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      case (state)
        IDLE: if (go) begin
          state <= WRITE;
          err   <= err_n;
          wr_en <= !err_n;
          if (!err_n) begin
            wr_idx  <= idx_n[IW-1:0];
            wr_data <= data_n;
            wr_strb <= strb_n;
          end
        end
        WRITE: begin
          state  <= RESP;
          BVALID <= 1'b1;
          BRESP  <= err ? 2'b10 : 2'b00;
        end
        default: if (BREADY) begin
          state   <= IDLE;
          BVALID  <= 1'b0;
          aw_full <= 1'b0;
          w_full  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_amba_axi4_lite_write_slave.sv
// tb_amba_axi4_lite_write_slave: checks two instances (PRIV_ONLY 0 and 1) driven by shared stimulus against a transaction-level model.
module tb_amba_axi4_lite_write_slave;
  logic ACLK, ARESETn, AWVALID, WVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [2:0] AWPROT;
  logic [3:0] WSTRB;
  logic [1:0] awready, wready, bvalid, wr_en;
  logic [1:0] bresp [2];
  logic [3:0] wr_idx [2];
  logic [31:0] wr_data [2];
  logic [3:0] wr_strb [2];
  logic [3:0] m_idx [2];
  logic [31:0] m_data [2];
  logic [3:0] m_strb [2];
  int n_pass = 0, n_fail = 0, n_total = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    amba_axi4_lite_write_slave #(.PRIV_ONLY(g)) u_dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWVALID(AWVALID), .AWREADY(awready[g]), .AWADDR(AWADDR), .AWPROT(AWPROT),
      .WVALID(WVALID), .WREADY(wready[g]), .WDATA(WDATA), .WSTRB(WSTRB),
      .BVALID(bvalid[g]), .BREADY(BREADY), .BRESP(bresp[g]),
      .wr_en(wr_en[g]), .wr_idx(wr_idx[g]), .wr_data(wr_data[g]), .wr_strb(wr_strb[g])
    );
  end
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic ref_err(input logic [31:0] a, input logic [2:0] p, input int priv);
    return (a / 4 >= 16) || (priv == 1 && p[0] == 1'b0);
  endfunction
  task automatic idle_checks(input logic exp_rdy);
    for (int k = 0; k < 2; k++) begin
      chk("awready_idle", awready[k], exp_rdy);
      chk("wready_idle", wready[k], exp_rdy);
      chk("bvalid_idle", bvalid[k], 1'b0);
      chk("wr_en_idle", wr_en[k], 1'b0);
      chk("wr_idx_hold", wr_idx[k], m_idx[k]);
      chk("wr_data_hold", wr_data[k], m_data[k]);
      chk("wr_strb_hold", wr_strb[k], m_strb[k]);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = '0;
      m_data[k] = '0;
      m_strb[k] = '0;
    end
  endtask
  // Entered and left just after a rising edge. Once a channel has handshaken its VALID stays high with
  // different payload to confirm the second beat is stalled until the response completes.
  task automatic txn(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d, input logic [3:0] s,
                     input int aw_dly, input int w_dly, input int b_hold);
    logic e [2];
    int n_we [2], f_we [2], f_bv [2];
    int c2, bv_cnt, cyc, b_cyc;
    logic aw_done, w_done, b_done, hs_aw, hs_w, hs_b;
    for (int k = 0; k < 2; k++) begin
      e[k] = ref_err(a, p, k);
      n_we[k] = 0;
      f_we[k] = -1;
      f_bv[k] = -1;
    end
    aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
    bv_cnt = 0; cyc = 0; c2 = -1; b_cyc = -1;
    while (!b_done && cyc < 60) begin
      AWVALID = cyc >= aw_dly;
      AWADDR  = aw_done ? ~a : a;
      AWPROT  = p;
      WVALID  = cyc >= w_dly;
      WDATA   = w_done ? ~d : d;
      WSTRB   = w_done ? ~s : s;
      BREADY  = bv_cnt >= b_hold;
      @(negedge ACLK);
      for (int k = 0; k < 2; k++) begin
        chk("awready", awready[k], !aw_done);
        chk("wready", wready[k], !w_done);
        if (wr_en[k]) begin
          n_we[k]++;
          if (f_we[k] < 0) f_we[k] = cyc;
          chk("wr_idx", wr_idx[k], (a / 4) % 16);
          chk("wr_data", wr_data[k], d);
          chk("wr_strb", wr_strb[k], s);
        end
        if (bvalid[k]) begin
          if (f_bv[k] < 0) f_bv[k] = cyc;
          chk("bresp", bresp[k], e[k] ? 2'b10 : 2'b00);
        end
      end
      hs_aw = AWVALID && awready[0];
      hs_w  = WVALID && wready[0];
      hs_b  = BREADY && bvalid[0];
      if (bvalid[0]) bv_cnt++;
      @(posedge ACLK);
      #1;
      if (hs_b) begin
        b_done = 1'b1;
        b_cyc = cyc;
      end
      aw_done |= hs_aw;
      w_done |= hs_w;
      if (c2 < 0 && aw_done && w_done) c2 = cyc;
      cyc++;
    end
    chk("b_done", b_done, 1'b1);
    AWVALID = 1'b0;
    WVALID = 1'b0;
    BREADY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("we_count", n_we[k], e[k] ? 0 : 1);
      if (!e[k]) begin
        chk("we_lat", f_we[k], c2 + 1);
        m_idx[k] = 4'((a / 4) % 16);
        m_data[k] = d;
        m_strb[k] = s;
      end
      chk("bv_lat", f_bv[k], c2 + 2);
      chk("b_lat", b_cyc - f_bv[k], b_hold);
    end
    @(negedge ACLK);
    idle_checks(1'b1);
    @(posedge ACLK);
    #1;
  endtask
  initial begin
    logic [31:0] ra, rd;
    logic [3:0] rs;
    ARESETn = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    AWADDR = '0; AWPROT = '0; WDATA = '0; WSTRB = '0;
    model_reset();
    @(negedge ACLK);
    for (int k = 0; k < 2; k++) chk("rst_bresp", bresp[k], 2'b00);
    idle_checks(1'b0);
    #2 ARESETn = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk("rdy_before_run", awready[k] | wready[k], 1'b0);
    @(posedge ACLK);
    #1;
    for (int k = 0; k < 2; k++) chk("rdy_after_run", {awready[k], wready[k]}, 2'b11);
    txn(32'h08, 3'b001, 32'hDEADBEEF, 4'hF, 0, 3, 0);
    txn(32'h3C, 3'b001, 32'h12345678, 4'h5, 3, 0, 0);
    txn(32'h3C, 3'b011, 32'hCAFEF00D, 4'hA, 0, 0, 0);
    txn(32'h40, 3'b001, 32'h11111111, 4'hF, 0, 0, 0);
    txn(32'h80000000, 3'b001, 32'h22222222, 4'hF, 1, 0, 0);
    txn(32'h10, 3'b000, 32'h33333333, 4'h3, 1, 1, 0);
    txn(32'h14, 3'b001, 32'h44444444, 4'hC, 0, 1, 0);
    txn(32'h04, 3'b001, 32'h66666666, 4'h9, 0, 0, 10);
    txn(32'h20, 3'b001, 32'h00000000, 4'h0, 0, 2, 0);
    AWVALID = 1'b1; AWADDR = 32'h18; AWPROT = 3'b001;
    WVALID = 1'b1; WDATA = 32'h5555AAAA; WSTRB = 4'hF; BREADY = 1'b0;
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
    WVALID = 1'b0;
    for (int n = 0; n < 10 && !bvalid[0]; n++) begin
      @(posedge ACLK);
      #1;
    end
    chk("resp_reached", bvalid, 2'b11);
    #2 ARESETn = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_bvalid_async", bvalid[k], 1'b0);
      chk("rst_bresp_async", bresp[k], 2'b00);
      chk("rst_wr_data_async", wr_data[k], 32'h0);
      chk("rst_rdy_async", {awready[k], wready[k]}, 2'b00);
    end
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    for (int k = 0; k < 2; k++) chk("rdy_before_run2", {awready[k], wready[k]}, 2'b00);
    @(negedge ACLK);
    idle_checks(1'b0);
    @(posedge ACLK);
    #1;
    repeat (2) begin
      @(negedge ACLK);
      idle_checks(1'b1);
    end
    @(posedge ACLK);
    #1;
    txn(32'h2C, 3'b101, 32'h0BADF00D, 4'h6, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      ra = $urandom_range(0, 9) == 0 ? $urandom : {26'($urandom_range(0, 17)), 4'b0} >> 2;
      ra = ra | 32'($urandom_range(0, 3));
      rd = $urandom;
      rs = $urandom_range(0, 5) == 0 ? 4'h0 : 4'($urandom_range(0, 15));
      txn(ra, 3'($urandom_range(0, 7)), rd, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
